// File: rtl/arcade_input_pkg.sv
// Shared types, function codes and the PS/2 keymap for the arcade input front end.
package arcade_input_pkg;

    typedef struct packed {
        logic [8:0] code;
        logic       wild_ext;
        logic [1:0] player;
        logic [3:0] func;
    } key_entry_t;

    localparam logic [3:0] FN_UP    = 4'd0;
    localparam logic [3:0] FN_DOWN  = 4'd1;
    localparam logic [3:0] FN_LEFT  = 4'd2;
    localparam logic [3:0] FN_RIGHT = 4'd3;
    localparam logic [3:0] FN_BTN0  = 4'd4;
    localparam logic [3:0] FN_BTN1  = 4'd5;
    localparam logic [3:0] FN_BTN2  = 4'd6;
    localparam logic [3:0] FN_BTN3  = 4'd7;
    localparam logic [3:0] FN_BTN4  = 4'd8;
    localparam logic [3:0] FN_BTN5  = 4'd9;
    localparam logic [3:0] FN_START = 4'd10;
    localparam logic [3:0] FN_COIN  = 4'd11;

    localparam int unsigned NUM_FUNCS = 12;

    localparam logic [7:0] PS2_F0 = 8'hF0;
    localparam logic [7:0] PS2_E0 = 8'hE0;

    localparam int unsigned KEYMAP_LEN = 28;

    // Arrow keys arrive with or without the E0 prefix depending on NumLock, hence wild_ext.
    localparam key_entry_t KEYMAP [KEYMAP_LEN] = '{
        '{9'h075, 1'b1, 2'd0, FN_UP},    '{9'h072, 1'b1, 2'd0, FN_DOWN},
        '{9'h06B, 1'b1, 2'd0, FN_LEFT},  '{9'h074, 1'b1, 2'd0, FN_RIGHT},
        '{9'h029, 1'b0, 2'd0, FN_BTN0},  '{9'h011, 1'b0, 2'd0, FN_BTN1},
        '{9'h014, 1'b0, 2'd0, FN_BTN2},  '{9'h012, 1'b0, 2'd0, FN_BTN3},
        '{9'h01A, 1'b0, 2'd0, FN_BTN4},  '{9'h022, 1'b0, 2'd0, FN_BTN5},
        '{9'h005, 1'b0, 2'd0, FN_START}, '{9'h02E, 1'b0, 2'd0, FN_COIN},
        '{9'h02D, 1'b0, 2'd1, FN_UP},    '{9'h02B, 1'b0, 2'd1, FN_DOWN},
        '{9'h023, 1'b0, 2'd1, FN_LEFT},  '{9'h034, 1'b0, 2'd1, FN_RIGHT},
        '{9'h01C, 1'b0, 2'd1, FN_BTN0},  '{9'h01B, 1'b0, 2'd1, FN_BTN1},
        '{9'h015, 1'b0, 2'd1, FN_BTN2},  '{9'h01D, 1'b0, 2'd1, FN_BTN3},
        '{9'h024, 1'b0, 2'd1, FN_BTN4},  '{9'h02C, 1'b0, 2'd1, FN_BTN5},
        '{9'h006, 1'b0, 2'd1, FN_START}, '{9'h036, 1'b0, 2'd1, FN_COIN},
        '{9'h004, 1'b0, 2'd2, FN_START}, '{9'h03D, 1'b0, 2'd2, FN_COIN},
        '{9'h00C, 1'b0, 2'd3, FN_START}, '{9'h03E, 1'b0, 2'd3, FN_COIN}
    };

    function automatic logic key_match(input key_entry_t e, input logic [8:0] code);
        return (e.code[7:0] == code[7:0]) && (e.wild_ext || (e.code[8] == code[8]));
    endfunction

endpackage

// File: rtl/input_pulse_stretch.sv
// Rising-edge detector that stretches each accepted edge into a CYCLES-long pulse.
module input_pulse_stretch #(
    parameter int unsigned CYCLES = 1
) (
    input  logic clk_i,
    input  logic rst_i,
    input  logic level_i,
    output logic pulse_o
);

    localparam int unsigned CntW = (CYCLES > 1) ? $clog2(CYCLES) : 1;

    logic [CntW-1:0] cnt_q, cnt_d;
    logic            level_q;
    logic            pulse_q, pulse_d;

    always_comb begin
        cnt_d   = cnt_q;
        pulse_d = pulse_q;
        if (cnt_q == '0) begin
            if (level_i && !level_q) begin
                cnt_d   = CntW'(CYCLES - 1);
                pulse_d = 1'b1;
            end else begin
                pulse_d = 1'b0;
            end
        end else begin
            cnt_d = cnt_q - 1'b1;
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            cnt_q   <= '0;
            level_q <= 1'b0;
            pulse_q <= 1'b0;
        end else begin
            cnt_q   <= cnt_d;
            level_q <= level_i;
            pulse_q <= pulse_d;
        end
    end

    assign pulse_o = pulse_q;

endmodule

// File: rtl/arcade_input_mapper.sv
// Merges PS/2 key events and joysticks into per-player control vectors.
// Define INPUT_SOCD_EN to neutralise opposite directions after rotation.
module arcade_input_mapper
    import arcade_input_pkg::*;
#(
    parameter int unsigned NUM_PLAYERS       = 2,
    parameter int unsigned NUM_BUTTONS       = 2,
    parameter int unsigned COIN_PULSE_CYCLES = 4800000
) (
    input  logic                               clk_sys,
    input  logic                               reset,
    input  logic [65:0]                        ps2_key,
    input  logic [NUM_PLAYERS*16-1:0]          joystick,
    input  logic                               joy_merge,
    input  logic                               rotate,
    output logic [NUM_PLAYERS*4-1:0]           p_dir,
    output logic [NUM_PLAYERS*NUM_BUTTONS-1:0] p_btn,
    output logic [NUM_PLAYERS-1:0]             p_start,
    output logic [NUM_PLAYERS-1:0]             p_coin
);

    logic                                      arm_q, old_tog_q;
    logic [NUM_PLAYERS-1:0][NUM_FUNCS-1:0]     key_q, key_d;
    logic                                      pressed, ext, key_evt;
    logic [8:0]                                code;

    always_comb begin
        pressed = (ps2_key[15:8] != PS2_F0);
        ext     = pressed ? (ps2_key[15:8] == PS2_E0) : (ps2_key[23:16] == PS2_E0);
        code    = {ext, ps2_key[7:0]};
        // Multi-byte PRNSCR/PAUSE sequences populate the upper bytes and are dropped
        key_evt = arm_q && (ps2_key[64] != old_tog_q) && (ps2_key[63:24] == '0);
        key_d   = key_q;
        if (key_evt) begin
            for (int p = 0; p < int'(NUM_PLAYERS); p++) begin
                for (int f = 0; f < int'(NUM_FUNCS); f++) begin
                    for (int i = 0; i < int'(KEYMAP_LEN); i++) begin
                        if (int'(KEYMAP[i].player) == p && int'(KEYMAP[i].func) == f &&
                            key_match(KEYMAP[i], code)) begin
                            key_d[p][f] = pressed;
                        end
                    end
                end
            end
        end
    end

    logic [15:0]                               joy_or, jw;
    logic [3:0]                                dir;
    logic [NUM_PLAYERS-1:0][3:0]               dir_d, dir_q;
    logic [NUM_PLAYERS-1:0][NUM_BUTTONS-1:0]   btn_d, btn_q;
    logic [NUM_PLAYERS-1:0]                    start_d, start_q, coin_raw;
    logic                                      unused_bits;

    always_comb begin
        joy_or      = '0;
        jw          = '0;
        dir         = '0;
        dir_d       = '0;
        btn_d       = '0;
        start_d     = '0;
        coin_raw    = '0;
        unused_bits = ps2_key[65];
        for (int p = 0; p < int'(NUM_PLAYERS); p++) begin
            joy_or = joy_or | joystick[16*p +: 16];
        end
        for (int p = 0; p < int'(NUM_PLAYERS); p++) begin
            if (joy_merge) begin
                jw = (p == 0) ? joy_or : 16'h0000;
            end else begin
                jw = joystick[16*p +: 16];
            end
            dir = {key_q[p][FN_UP], key_q[p][FN_DOWN], key_q[p][FN_LEFT], key_q[p][FN_RIGHT]}
                | jw[3:0];
            // {up,down,left,right} <= {left,right,down,up}
            if (rotate) begin
                dir = {dir[1], dir[0], dir[2], dir[3]};
            end
`ifdef INPUT_SOCD_EN
            if (dir[3] && dir[2]) begin
                dir[3:2] = 2'b00;
            end
            if (dir[1] && dir[0]) begin
                dir[1:0] = 2'b00;
            end
`endif
            dir_d[p] = dir;
            for (int b = 0; b < int'(NUM_BUTTONS); b++) begin
                btn_d[p][b] = key_q[p][int'(FN_BTN0) + b] | jw[4 + b];
            end
            start_d[p]  = key_q[p][FN_START] | jw[4 + NUM_BUTTONS];
            coin_raw[p] = key_q[p][FN_COIN] | jw[5 + NUM_BUTTONS];
            unused_bits = unused_bits ^ (^jw) ^ (^key_q[p]);
        end
    end

    always_ff @(posedge clk_sys or posedge reset) begin
        if (reset) begin
            arm_q     <= 1'b0;
            old_tog_q <= 1'b0;
            key_q     <= '0;
            dir_q     <= '0;
            btn_q     <= '0;
            start_q   <= '0;
        end else begin
            arm_q     <= 1'b1;
            old_tog_q <= ps2_key[64];
            key_q     <= key_d;
            dir_q     <= dir_d;
            btn_q     <= btn_d;
            start_q   <= start_d;
        end
    end

    assign p_dir   = dir_q;
    assign p_btn   = btn_q;
    assign p_start = start_q;

    for (genvar p = 0; p < NUM_PLAYERS; p++) begin : g_coin
        input_pulse_stretch #(
            .CYCLES (COIN_PULSE_CYCLES)
        ) u_stretch (
            .clk_i   (clk_sys),
            .rst_i   (reset),
            .level_i (coin_raw[p]),
            .pulse_o (p_coin[p])
        );
    end

endmodule

// File: doc/arcade_input_mapper.md
Name: arcade_input_mapper

Overview:
Parametrised input front end for arcade cores. It merges PS/2 keyboard events and HPS joysticks into per-player direction, button, start and coin vectors. It applies an optional 90° orientation remap and generates fixed-length coin pulses. It sits between hps_io and the core top and replaces per-core ad-hoc key decoding.

Parameters:
- NUM_PLAYERS, 2: player count, 1..4.
- NUM_BUTTONS, 2: action buttons per player, 1..6.
- COIN_PULSE_CYCLES, 4800000: coin output high time in clk_sys cycles (100 ms at 48 MHz); must be at least 1.

Ports:
- clk_sys, in, 1: system clock.
- reset, in, 1: asynchronous, active-high reset.
- ps2_key, in, 66: hps_io key event word; bit 64 toggles on each new event.
- joystick, in, NUM_PLAYERS*16: joystick j occupies bits [16j+15:16j].
- joy_merge, in, 1: when 1, OR all joysticks into player 0.
- rotate, in, 1: when 1, apply the orientation remap.
- p_dir, out, NUM_PLAYERS*4: per player {up,down,left,right}.
- p_btn, out, NUM_PLAYERS*NUM_BUTTONS: action buttons, button 0 in the LSB.
- p_start, out, NUM_PLAYERS: start buttons.
- p_coin, out, NUM_PLAYERS: stretched coin pulses.

Behaviour:
- Reset:
  - All outputs, key-state registers and coin counters clear to 0.
  - The toggle tracker clears and arm clears to 0.
- Event detect:
  - First clk_sys edge after reset release: set arm=1, copy ps2_key[64] into old_tog, no decode. A toggle already set at reset therefore produces no event.
  - After that, an event is any cycle with ps2_key[64] != old_tog. old_tog updates every cycle.
- Decode:
  - pressed = (ps2_key[15:8] != 8'hF0).
  - ext = pressed ? (ps2_key[15:8]==8'hE0) : (ps2_key[23:16]==8'hE0).
  - code = {ext, ps2_key[7:0]}.
  - If ps2_key[63:24] != 0, the event is discarded (PRNSCR/PAUSE).
  - A matching code sets its key-state bit to pressed. Unmapped codes are ignored.
  - Codes listed with X ignore the ext bit.
- Keymap, held in the package:
  - P0: arrows X75/X72/X6B/X74; buttons 029,011,014,012,01A,022; start 005 (F1); coin 02E (5).
  - P1: up 02D, down 02B, left 023, right 034; buttons 01C,01B,015,01D,024,02C; start 006 (F2); coin 036 (6).
  - P2 and P3: start F3/F4, coin 7/8, directions and buttons unmapped.
  - Buttons beyond NUM_BUTTONS are ignored.
- Joystick bit map (per 16-bit word):
  - [0] right, [1] left, [2] down, [3] up.
  - [4+k] button k.
  - [4+NUM_BUTTONS] start.
  - [5+NUM_BUTTONS] coin.
- Merge: raw_p = key_p | joy_p. If joy_merge=1, player 0 takes the OR of all joysticks and the other players take keyboard input only.
- Rotate (rotate=1), applied after merge:
  - up ← left, down ← right, left ← down, right ← up.
- Coin pulse, per player:
  - A rising edge of raw coin while the counter is 0 loads COIN_PULSE_CYCLES-1 and drives p_coin=1.
  - p_coin stays high while the counter is nonzero, then falls.
  - Edges during a pulse are ignored.
  - Holding coin gives exactly one pulse; a release is required before the next.
- Latency:
  - Joystick change to p_dir/p_btn/p_start: 1 clk (registered).
  - Key event to outputs: 2 clk (key-state register, then output register).
  - Coin edge to p_coin high: 2 clk from key, 1 clk from joystick.
- Simultaneous key and joystick activity: ORed. Release occurs only when both sources are inactive.
- Reset mid-pulse: p_coin drops immediately and the counter clears.

Optional Feature:
- Macro: INPUT_SOCD_EN.
- Defined: after rotation, opposite pairs resolve to neutral per player. up&down gives neither; left&right gives neither.
- Undefined: opposite directions pass through unchanged.

Decomposition:
- Package arcade_input_pkg holds:
  - the key_entry_t struct {code[8:0], wild_ext, player[1:0], func[3:0]};
  - the KEYMAP constant array;
  - function codes FN_UP, FN_DOWN, FN_LEFT, FN_RIGHT, FN_BTN0..5, FN_START, FN_COIN;
  - the PS/2 constants F0 and E0.
- Sub-module input_pulse_stretch (param CYCLES) implements the coin edge detector and counter, instantiated once per player.

Test Plan:
- Reset with ps2_key[64]=1, release, hold 10 clk → no output changes; then key 0x75 pressed with toggle → p_dir[3] (P0 up) =1 at cycle +2.
- Event {F0,75} toggled → P0 up returns to 0. Event with ps2_key[63:24]=1 and code 75 → ignored.
- rotate=1, joystick[1]=1 (left) → P0 up=1 after 1 clk; rotate=0 → P0 left=1.
- COIN_PULSE_CYCLES=8, joystick coin bit held 20 clk → exactly one 8-cycle p_coin[0] pulse. Release and re-press during the pulse → no extension.
- joy_merge=1, joystick word1 bit4 → p_btn[0]=1 for P0, P1 unaffected; joy_merge=0 → P1 btn0=1.
- With INPUT_SOCD_EN: keys up+down held → P0 up=0 and down=0. Without the macro → both 1.
